// File: rtl/psum_accum_sram_bank_if.sv
// Write/accumulate, read and status bundle for the psum SRAM bank.
// The master side is whoever produces psums and consumes read data; the bank is the slave.
interface psum_accum_sram_bank_if #(
  parameter int DATA_W = 21,
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 5
);
  logic                     psum_in_valid;
  logic                     psum_in_ready;
  logic signed [DATA_W-1:0] psum_in_data;
  logic                     psum_write_en;
  logic [ADDR_W-1:0]        psum_write_addr;
  logic                     psum_acc_mode;
  logic                     psum_write_done;
  logic [CNT_W-1:0]         cfg_psum_depth;
  logic                     psum_read_en;
  logic [ADDR_W-1:0]        psum_read_addr;
  logic                     psum_read_ready;
  logic                     psum_out_valid;
  logic                     psum_out_ready;
  logic signed [DATA_W-1:0] psum_out_data;
  logic                     psum_sat;
  logic                     psum_busy;

  modport master (
    output psum_in_valid, psum_in_data, psum_write_en, psum_write_addr, psum_acc_mode,
           cfg_psum_depth, psum_read_en, psum_read_addr, psum_out_ready,
    input  psum_in_ready, psum_write_done, psum_read_ready, psum_out_valid,
           psum_out_data, psum_sat, psum_busy
  );

  modport slave (
    input  psum_in_valid, psum_in_data, psum_write_en, psum_write_addr, psum_acc_mode,
           cfg_psum_depth, psum_read_en, psum_read_addr, psum_out_ready,
    output psum_in_ready, psum_write_done, psum_read_ready, psum_out_valid,
           psum_out_data, psum_sat, psum_busy
  );
endinterface

// File: rtl/psum_accum_sram_bank.sv
// Psum SRAM bank: overwrite or saturating read-modify-write accumulate on the write side,
// ready/valid read port with a held output register, and a batch counter with done pulse.
module psum_accum_sram_bank #(
  parameter int DATA_W = 21,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512,
  parameter int CNT_W  = 5
) (
  input logic clock,
  input logic reset_n,
  psum_accum_sram_bank_if.slave bus
);

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] mem [DEPTH];

  logic wr_hs;
  logic ow_fire;
  logic acc_fire;
  logic rd_hs;
  logic wr_in_range;
  logic rd_in_range;

  logic                     s1_valid_reg;
  logic [ADDR_W-1:0]        s1_addr_reg;
  logic signed [DATA_W-1:0] s1_data_reg;
  logic signed [DATA_W-1:0] s1_old_reg;
  logic                     s1_in_range_reg;

  logic [DATA_W:0]          sum_wide;
  logic                     acc_clamp;
  logic signed [DATA_W-1:0] acc_result;
  logic                     fwd_hit;

  logic                     out_valid_reg;
  logic                     out_valid_next;
  logic signed [DATA_W-1:0] rd_data_reg;

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             done_reg;
  logic             done_next;
  logic             sat_reg;

  // Address range qualification only costs logic when the array is not a full power of two.
  generate
    if (DEPTH < (1 << ADDR_W)) begin : g_range
      assign wr_in_range = ({{(32-ADDR_W){1'b0}}, bus.psum_write_addr} < DEPTH);
      assign rd_in_range = ({{(32-ADDR_W){1'b0}}, bus.psum_read_addr} < DEPTH);
    end else begin : g_full
      assign wr_in_range = 1'b1;
      assign rd_in_range = 1'b1;
    end
  endgenerate

  assign bus.psum_in_ready   = bus.psum_write_en;
  assign wr_hs               = bus.psum_in_valid & bus.psum_write_en;
  assign ow_fire             = wr_hs & ~bus.psum_acc_mode & wr_in_range;
  assign acc_fire            = wr_hs & bus.psum_acc_mode;

  // Accumulate borrows the read port whenever it could issue, so external reads back off.
  assign bus.psum_read_ready = ~(bus.psum_acc_mode & bus.psum_write_en) &
                               (~out_valid_reg | bus.psum_out_ready);
  assign rd_hs               = bus.psum_read_en & bus.psum_read_ready;

  assign sum_wide   = {s1_old_reg[DATA_W-1], s1_old_reg} + {s1_data_reg[DATA_W-1], s1_data_reg};
  assign acc_clamp  = sum_wide[DATA_W] ^ sum_wide[DATA_W-1];
  assign acc_result = acc_clamp ? (sum_wide[DATA_W] ? SAT_MIN : SAT_MAX) : sum_wide[DATA_W-1:0];
  assign fwd_hit    = s1_valid_reg & (bus.psum_write_addr == s1_addr_reg);

  // Storage and datapath registers; no reset so the array maps onto block RAM.
  always_ff @(posedge clock) begin
    if (s1_valid_reg && s1_in_range_reg) begin
      mem[s1_addr_reg] <= acc_result;
    end
    // A fresh overwrite is newer than the stage-1 result, so it lands last.
    if (ow_fire) begin
      mem[bus.psum_write_addr] <= bus.psum_in_data;
    end
    if (acc_fire) begin
      s1_addr_reg     <= bus.psum_write_addr;
      s1_data_reg     <= bus.psum_in_data;
      s1_in_range_reg <= wr_in_range;
      if (fwd_hit) begin
        s1_old_reg <= acc_result;
      end else if (wr_in_range) begin
        s1_old_reg <= mem[bus.psum_write_addr];
      end else begin
        s1_old_reg <= '0;
      end
    end
    if (rd_hs) begin
      rd_data_reg <= rd_in_range ? mem[bus.psum_read_addr] : '0;
    end
  end

  always_comb begin
    out_valid_next = out_valid_reg;
    if (rd_hs) begin
      out_valid_next = 1'b1;
    end else if (bus.psum_out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_comb begin
    count_next = count_reg;
    done_next  = 1'b0;
    if (wr_hs) begin
      if (count_reg == bus.cfg_psum_depth) begin
        count_next = '0;
        done_next  = 1'b1;
      end else begin
        count_next = count_reg + 1'b1;
      end
    end
  end

  // Clearing s1_valid here is what drops an in-flight accumulate on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      count_reg     <= '0;
      done_reg      <= 1'b0;
      sat_reg       <= 1'b0;
    end else begin
      s1_valid_reg  <= acc_fire;
      out_valid_reg <= out_valid_next;
      count_reg     <= count_next;
      done_reg      <= done_next;
      sat_reg       <= s1_valid_reg & acc_clamp;
    end
  end

  assign bus.psum_out_valid  = out_valid_reg;
  assign bus.psum_out_data   = out_valid_reg ? rd_data_reg : '0;
  assign bus.psum_write_done = done_reg;
  assign bus.psum_sat        = sat_reg;
  assign bus.psum_busy       = s1_valid_reg;

endmodule

// File: tb/tb_psum_accum_sram_bank.sv
// Directed bench for psum_accum_sram_bank: reset, overwrite batches, accumulate hazards,
// saturation, read backpressure and write/read collisions with hand-computed expectations.
module tb_psum_accum_sram_bank;
  localparam int DATA_W = 21;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;
  localparam int CNT_W  = 5;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  psum_accum_sram_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  psum_accum_sram_bank #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic signed [31:0] got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.psum_in_valid   = 1'b0;
    bus.psum_in_data    = '0;
    bus.psum_write_en   = 1'b0;
    bus.psum_write_addr = '0;
    bus.psum_acc_mode   = 1'b0;
    bus.psum_read_en    = 1'b0;
    bus.psum_read_addr  = '0;
    bus.psum_out_ready  = 1'b1;
  endtask

  task automatic drive_wr(input int addr, input int data, input bit acc);
    bus.psum_in_valid   = 1'b1;
    bus.psum_write_en   = 1'b1;
    bus.psum_write_addr = ADDR_W'(addr);
    bus.psum_in_data    = DATA_W'(data);
    bus.psum_acc_mode   = acc;
  endtask

  task automatic wr(input int addr, input int data, input bit acc);
    drive_wr(addr, data, acc);
    tick();
    bus.psum_in_valid = 1'b0;
    bus.psum_write_en = 1'b0;
    bus.psum_acc_mode = 1'b0;
  endtask

  task automatic rd_check(input string tag, input int addr, input int exp);
    bus.psum_out_ready = 1'b1;
    bus.psum_read_en   = 1'b1;
    bus.psum_read_addr = ADDR_W'(addr);
    tick();
    bus.psum_read_en = 1'b0;
    check({tag, "_valid"}, bus.psum_out_valid, 1);
    check(tag, bus.psum_out_data, exp);
    tick();
  endtask

  int t2_data [4] = '{10, -5, 7, 0};
  int t2_done [4] = '{0, 0, 0, 1};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    bus.cfg_psum_depth = CNT_W'(3);
    repeat (2) tick();
    check("rst_valid", bus.psum_out_valid, 0);
    check("rst_done", bus.psum_write_done, 0);
    reset_n = 1'b1;
    tick();

    // Reset mid-stream: held read word and an in-flight accumulate are both dropped.
    wr(20, 77, 1'b0);
    bus.psum_out_ready = 1'b0;
    bus.psum_read_en   = 1'b1;
    bus.psum_read_addr = ADDR_W'(20);
    tick();
    bus.psum_read_en = 1'b0;
    check("t1_held_valid", bus.psum_out_valid, 1);
    drive_wr(20, 5, 1'b1);
    tick();
    check("t1_busy", bus.psum_busy, 1);
    idle();
    reset_n = 1'b0;
    #1;
    check("t1_rst_valid", bus.psum_out_valid, 0);
    check("t1_rst_data", bus.psum_out_data, 0);
    check("t1_rst_busy", bus.psum_busy, 0);
    check("t1_rst_sat", bus.psum_sat, 0);
    check("t1_rst_done", bus.psum_write_done, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    rd_check("t1_keep", 20, 77);

    // Overwrite batch of 4 with cfg_psum_depth = 3, then streaming reads.
    for (int i = 0; i < 4; i++) begin
      drive_wr(i, t2_data[i], 1'b0);
      tick();
      check($sformatf("t2_done%0d", i), bus.psum_write_done, t2_done[i]);
    end
    idle();
    tick();
    check("t2_done_clr", bus.psum_write_done, 0);
    for (int i = 0; i < 4; i++) begin
      bus.psum_read_en   = 1'b1;
      bus.psum_read_addr = ADDR_W'(i);
      tick();
      check($sformatf("t2_rv%0d", i), bus.psum_out_valid, 1);
      check($sformatf("t2_rd%0d", i), bus.psum_out_data, t2_data[i]);
    end
    bus.psum_read_en = 1'b0;
    tick();
    check("t2_drain_valid", bus.psum_out_valid, 0);
    check("t2_drain_data", bus.psum_out_data, 0);

    // Back-to-back accumulates to one address: 100 + 1 + 2 + 3.
    wr(5, 100, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      drive_wr(5, i, 1'b1);
      tick();
      check($sformatf("t3_busy%0d", i), bus.psum_busy, 1);
      check($sformatf("t3_sat%0d", i), bus.psum_sat, 0);
      check($sformatf("t3_done%0d", i), bus.psum_write_done, (i == 3) ? 1 : 0);
    end
    idle();
    tick();
    check("t3_busy_clr", bus.psum_busy, 0);
    check("t3_sat_last", bus.psum_sat, 0);
    tick();
    rd_check("t3_sum", 5, 106);

    // Saturation at both rails; -1048576 is the most negative 21-bit operand.
    wr(9, 1048570, 1'b0);
    wr(9, 10, 1'b1);
    idle();
    check("t4_sat_pre", bus.psum_sat, 0);
    tick();
    check("t4_sat_hi", bus.psum_sat, 1);
    tick();
    check("t4_sat_hi_clr", bus.psum_sat, 0);
    rd_check("t4_max", 9, 1048575);
    wr(9, -5, 1'b0);
    wr(9, -1048576, 1'b1);
    idle();
    tick();
    check("t4_sat_lo", bus.psum_sat, 1);
    tick();
    rd_check("t4_min", 9, -1048576);

    // Backpressure: word from addr 2 held while addr 3 waits, then both drain in order.
    wr(2, 222, 1'b0);
    wr(3, 333, 1'b0);
    bus.psum_out_ready = 1'b0;
    bus.psum_read_en   = 1'b1;
    bus.psum_read_addr = ADDR_W'(2);
    tick();
    check("t5_first", bus.psum_out_data, 222);
    bus.psum_read_addr = ADDR_W'(3);
    #1;
    check("t5_rr_blocked", bus.psum_read_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t5_hold%0d", i), bus.psum_out_data, 222);
      check($sformatf("t5_rr%0d", i), bus.psum_read_ready, 0);
    end
    bus.psum_out_ready = 1'b1;
    #1;
    check("t5_rr_open", bus.psum_read_ready, 1);
    tick();
    bus.psum_read_en = 1'b0;
    check("t5_second", bus.psum_out_data, 333);
    tick();
    check("t5_drained", bus.psum_out_valid, 0);

    // Same-cycle overwrite and read of addr 4 returns the old word.
    wr(4, 8, 1'b0);
    drive_wr(4, 9, 1'b0);
    bus.psum_read_en   = 1'b1;
    bus.psum_read_addr = ADDR_W'(4);
    #1;
    check("t6_rr_ow", bus.psum_read_ready, 1);
    tick();
    idle();
    check("t6_old", bus.psum_out_data, 8);
    tick();
    rd_check("t6_new", 4, 9);
    bus.psum_acc_mode = 1'b1;
    bus.psum_write_en = 1'b1;
    #1;
    check("t6_rr_acc", bus.psum_read_ready, 0);
    check("t6_in_ready", bus.psum_in_ready, 1);
    bus.psum_write_en = 1'b0;
    #1;
    check("t6_rr_acc_off", bus.psum_read_ready, 1);
    check("t6_in_ready_off", bus.psum_in_ready, 0);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
